// File: rtl/conv2_accumulate_stage_if.sv
// conv2_accumulate_stage_if: the product-beat input bundle and the pixel output
// bundle of the Layer-2 accumulation stage. The upstream multiplier stage uses the
// master side, and the accumulation stage uses the slave side.
interface conv2_accumulate_stage_if;
  logic               enable;
  logic               in_valid;
  logic signed [11:0] product1;
  logic signed [11:0] product2;
  logic signed [11:0] product3;
  logic signed [11:0] product4;
  logic signed [11:0] product5;
  logic signed [11:0] product6;
  logic signed [11:0] bias;
  logic signed [5:0]  pixel_out;
  logic               out_valid;
  logic               busy;

  modport master (
    output enable, in_valid, product1, product2, product3, product4, product5,
           product6, bias,
    input  pixel_out, out_valid, busy
  );

  modport slave (
    input  enable, in_valid, product1, product2, product3, product4, product5,
           product6, bias,
    output pixel_out, out_valid, busy
  );
endinterface

// File: rtl/conv2_accumulate_stage.sv
// conv2_accumulate_stage: Layer-2 convolution accumulation stage.
// The block sums six signed products per beat in S1 and accumulates BEATS beats in S2.
// In S3 it shifts the accumulator, saturates the result to signed 6 bits and emits one pixel.
// Build option: define CONV2_RELU_EN to clamp negative shifted results to 0 in S3.
module conv2_accumulate_stage #(
  parameter int BEATS = 4,
  parameter int SHIFT = 4,
  parameter int ACC_W = 20
) (
  input logic                     clk,
  input logic                     rst_n,
  conv2_accumulate_stage_if.slave bus
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = 31;
  localparam logic signed [ACC_W-1:0] PIX_MIN = -32;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        beat_cnt, beat_cnt_nxt;
  logic                    accept, is_first, is_last;
  logic signed [14:0]      sum6;

  logic                    s1_valid, s1_first, s1_last;
  logic signed [14:0]      s1_sum;
  logic signed [11:0]      s1_bias;
  logic                    s2_valid, s2_last;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [5:0]       sat_pix;
  logic signed [5:0]       pixel_q;
  logic                    out_valid_q;

  assign accept   = bus.enable && bus.in_valid;
  assign is_first = (state == IDLE);
  assign is_last  = (beat_cnt == LAST_CNT);
  assign sum6     = 15'(bus.product1) + 15'(bus.product2) + 15'(bus.product3)
                  + 15'(bus.product4) + 15'(bus.product5) + 15'(bus.product6);

  // Window FSM state and beat counter register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so that every register samples pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next-state logic: open, advance and close the window on accepted beats. A low enable aborts the window.
  always_comb begin
    // NOTE: defaults come first so that every path assigns every output and no latch is inferred.
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: if (accept) begin
        if (is_last) begin
          beat_cnt_nxt = '0;
        end else begin
          state_nxt    = ACCUM;
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      ACCUM: if (accept) begin
        if (is_last) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end else begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!bus.enable) begin
      state_nxt    = IDLE;
      beat_cnt_nxt = '0;
    end
  end

  // S1 operand capture: only accepted beats load, so these registers hold on idle cycles.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers carry no reset; s1_valid qualifies them.
    if (accept) begin
      s1_sum   <= sum6;
      s1_first <= is_first;
      s1_last  <= is_last;
      s1_bias  <= bus.bias;
    end
  end

  // S1/S2 valid flags and the accumulator. A low enable flushes everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      acc      <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= bus.enable && s1_valid;
      s2_last  <= s1_last;
      if (bus.enable && s1_valid) begin
        acc <= s1_first ? (ACC_W'(s1_bias) + ACC_W'(s1_sum)) : (acc + ACC_W'(s1_sum));
      end
    end
  end

  // Requantisation: arithmetic shift, optional ReLU, then saturate to signed 6 bits.
  always_comb begin
    shifted = acc >>> SHIFT;
`ifdef CONV2_RELU_EN
    if (shifted < 0) shifted = '0;
`else
`endif
    sat_pix = shifted[5:0];
    if (shifted > PIX_MAX)      sat_pix = 6'sd31;
    else if (shifted < PIX_MIN) sat_pix = -6'sd32;
  end

  // S3 output register: this stage loads a pixel only when S2 holds a completed window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pixel_q     <= '0;
    end else begin
      out_valid_q <= bus.enable && s2_valid && s2_last;
      if (bus.enable && s2_valid && s2_last) pixel_q <= sat_pix;
    end
  end

  assign bus.pixel_out = pixel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state == ACCUM) || s1_valid || s2_valid;
endmodule

// File: tb/tb_conv2_accumulate_stage.sv
// tb_conv2_accumulate_stage: this bench drives directed scenarios and then randomized beats.
// A window-level reference model predicts out_valid, busy and pixel_out on every cycle.
module tb_conv2_accumulate_stage;
  localparam int BEATS = 4;
  localparam int SHIFT = 4;

  logic clk;
  logic rst_n;
  conv2_accumulate_stage_if bus();

  conv2_accumulate_stage #(.BEATS(BEATS), .SHIFT(SHIFT), .ACC_W(20)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: open window, completed pixels waiting for their due edge.
  logic signed [11:0] cur_p [6];
  logic signed [11:0] cur_b;
  int win_cnt;
  int win_acc;
  int pend_due[$];
  int pend_val[$];
  int exp_pix;
  int exp_ov;
  int exp_busy;
  int n;
  int pulse_edge[$];
  int pulse_val[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask

  function automatic int requant(input int a);
    int v;
    v = a >>> SHIFT;
`ifdef CONV2_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 31) v = 31;
    if (v < -32) v = -32;
    return v;
  endfunction

  // The model advances by one rising edge using the inputs that were present at that edge.
  task automatic model_edge(input logic en, input logic vld);
    int s;
    exp_ov = 0;
    if (!rst_n) begin
      win_cnt = 0;
      pend_due.delete();
      pend_val.delete();
      exp_pix = 0;
    end else if (!en) begin
      win_cnt = 0;
      pend_due.delete();
      pend_val.delete();
    end else begin
      if (pend_due.size() > 0 && pend_due[0] == n) begin
        exp_ov  = 1;
        exp_pix = pend_val[0];
        void'(pend_due.pop_front());
        void'(pend_val.pop_front());
      end
      if (vld) begin
        s = 0;
        for (int i = 0; i < 6; i++) s += int'(cur_p[i]);
        if (win_cnt == 0) win_acc = int'(cur_b) + s;
        else              win_acc += s;
        win_cnt++;
        if (win_cnt == BEATS) begin
          pend_due.push_back(n + 2);
          pend_val.push_back(requant(win_acc));
          win_cnt = 0;
        end
      end
    end
    exp_busy = (win_cnt > 0 || pend_due.size() > 0) ? 1 : 0;
  endtask

  task automatic cycle(input logic en, input logic vld);
    bus.enable   = en;
    bus.in_valid = vld;
    bus.product1 = cur_p[0];
    bus.product2 = cur_p[1];
    bus.product3 = cur_p[2];
    bus.product4 = cur_p[3];
    bus.product5 = cur_p[4];
    bus.product6 = cur_p[5];
    bus.bias     = cur_b;
    @(posedge clk);
    model_edge(en, vld);
    #1;
    check("out_valid", int'(bus.out_valid), exp_ov);
    check("busy", int'(bus.busy), exp_busy);
    check("pixel_out", int'(bus.pixel_out), exp_pix);
    if (bus.out_valid) begin
      pulse_edge.push_back(n);
      pulse_val.push_back(int'(bus.pixel_out));
    end
    n++;
  endtask

  task automatic set_all(input int p, input int b);
    for (int i = 0; i < 6; i++) cur_p[i] = 12'(p);
    cur_b = 12'(b);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic window(input int gap);
    for (int b = 0; b < BEATS; b++) begin
      cycle(1'b1, 1'b1);
      if (b != BEATS - 1) idle(gap);
    end
  endtask

  int last_beat;

  initial begin
    n = 0; win_cnt = 0; win_acc = 0; exp_pix = 0; exp_ov = 0; exp_busy = 0;
    rst_n = 1'b0;
    set_all(0, 0);

    // Hold reset for two cycles while driving random inputs with in_valid set.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 6; j++) cur_p[j] = 12'($urandom);
      cur_b = 12'($urandom);
      cycle(1'b1, 1'b1);
    end
    rst_n = 1'b1;
    idle(2);

    // Nominal window: 6*10*4+16 = 256 >>> 4 = 16, out_valid visible in the third cycle after beat 4.
    pulse_edge.delete(); pulse_val.delete();
    set_all(10, 16);
    window(0);
    last_beat = n - 1;
    idle(4);
    check("nom_count", pulse_val.size(), 1);
    if (pulse_val.size() > 0) begin
      check("nom_val", pulse_val[0], 16);
      check("nom_lat_edges", pulse_edge[0] - last_beat, 2);
    end

    // Positive saturation with 2-cycle gaps: acc 24000 -> 1500 -> 31.
    pulse_edge.delete(); pulse_val.delete();
    set_all(1000, 0);
    window(2);
    idle(4);
    check("sat_count", pulse_val.size(), 1);
    if (pulse_val.size() > 0) check("sat_val", pulse_val[0], 31);

    // Negative path: acc -2400 -> -150 -> -32, or 0 when ReLU is built in.
    pulse_edge.delete(); pulse_val.delete();
    set_all(-100, 0);
    window(0);
    idle(4);
    check("neg_count", pulse_val.size(), 1);
`ifdef CONV2_RELU_EN
    if (pulse_val.size() > 0) check("neg_val", pulse_val[0], 0);
`else
    if (pulse_val.size() > 0) check("neg_val", pulse_val[0], -32);
`endif

    // Back-to-back windows with no bubble: outputs 1 then 0, four cycles apart.
    pulse_edge.delete(); pulse_val.delete();
    set_all(1, 0);
    window(0);
    set_all(2, -48);
    window(0);
    idle(4);
    check("b2b_count", pulse_val.size(), 2);
    if (pulse_val.size() == 2) begin
      check("b2b_val_a", pulse_val[0], 1);
      check("b2b_val_b", pulse_val[1], 0);
      check("b2b_spacing", pulse_edge[1] - pulse_edge[0], 4);
    end

    // Abort after beat 2, then a fresh window: only the fresh window produces a pixel.
    pulse_edge.delete(); pulse_val.delete();
    set_all(10, 16);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    window(0);
    idle(4);
    check("abort_count", pulse_val.size(), 1);
    if (pulse_val.size() > 0) check("abort_val", pulse_val[0], 16);

    // Drop enable right after a completed last beat, which must discard that in-flight pixel.
    pulse_edge.delete(); pulse_val.delete();
    set_all(-7, 100);
    window(0);
    cycle(1'b0, 1'b0);
    idle(4);
    check("flush_count", pulse_val.size(), 0);

    // Randomized phase: random data, gaps, enable drops and rare resets.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int j = 0; j < 6; j++) cur_p[j] = 12'($urandom);
      cur_b = 12'($urandom);
      cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0));
    end
    rst_n = 1'b1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv2_accumulate_stage.md
Name: conv2_accumulate_stage

Overview:
- Accumulation stage of Convolution Layer 2. Sits directly downstream of the Layer-2 multiplication stage.
- Each valid beat delivers six signed 12-bit products. The block sums the six products through a registered adder tree and accumulates BEATS beats into one output pixel.
- Once per window it adds a bias, arithmetic-shifts, optionally applies ReLU, and saturates the result to signed 6-bit for the next layer.

Parameters:
- BEATS, 4: product beats per output pixel (window length); must be >= 1.
- SHIFT, 4: arithmetic right shift applied after bias add (requantisation).
- ACC_W, 20: accumulator width; must be >= 16 + clog2(BEATS).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  stage enable; low aborts any open window and flushes the pipeline.
- in_valid  input  1  product beat valid; driven by the multiplication stage's done.
- product1..product6  input  12 each, signed  products from the multiplication stage.
- bias  input  12, signed  per-pixel bias; sampled on the first beat of each window.
- pixel_out  output  6, signed  requantised output pixel.
- out_valid  output  1  one-cycle pulse when pixel_out is updated.
- busy  output  1  high while a window is open or results are in flight.

Behaviour:
- Reset, when rst_n is low at a rising edge:
  - pixel_out=0, out_valid=0, busy=0.
  - beat_cnt=0, state=IDLE.
  - All pipeline valid flags cleared; accumulator=0.
- Reset mid-window discards all partial data.
- FSM states:
  - IDLE: no window open.
  - ACCUM: window open, beat_cnt beats received.
- Transitions:
  - IDLE -> ACCUM on an accepted beat when BEATS>1.
  - ACCUM -> IDLE on the accepted beat with beat_cnt==BEATS-1.
  - With BEATS==1, every accepted beat is both first and last; the FSM stays in IDLE.
- Beat acceptance:
  - A beat is accepted when enable && in_valid.
  - beat_cnt increments per accepted beat and wraps to 0 on the last beat.
  - in_valid low mid-window: hold state and count; gaps of any length are allowed.
- Pipeline stages:
  - S1 (cycle t+1): registers sum6 = sign-extended sum of the six products (15-bit), plus first/last flags and bias.
  - S2 (cycle t+2): if first, acc = sext(bias) + sum6; else acc = acc + sum6.
  - S3 (cycle t+3): if S2 held a last beat, pixel_out = sat6(relu?(acc >>> SHIFT)) and out_valid=1. Otherwise out_valid=0 and pixel_out holds.
- Latency: 3 cycles from the accepted last beat to out_valid.
- Back-to-back windows: the next window's first beat may arrive the cycle after the previous last beat, with no bubble. Throughput is one beat per cycle.
- Shift is arithmetic, rounding toward negative infinity.
- Saturation: results > 31 give 31; results < -32 give -32.
- enable low at any edge (rst_n high):
  - beat_cnt=0, state=IDLE, S1/S2 valid flags cleared, out_valid=0.
  - pixel_out holds its last value; the partial window is discarded.
  - An in-flight completed window whose last beat is already in S1/S2 is also discarded.
- busy = (state==ACCUM) || S1 valid || S2 valid.
- Inputs are not registered when not accepted (operand gating); the S1 register holds its value on cycles without an accepted beat.

Optional Feature:
- Macro: CONV2_RELU_EN.
- Defined: negative shifted results are clamped to 0 before saturation, so pixel_out is in 0..31.
- Undefined: no ReLU; pixel_out spans -32..31.
- The ReLU is in S3 only, so latency is identical in both builds.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles with random inputs and in_valid=1 -> pixel_out=0, out_valid=0, busy=0 throughout.
- Nominal window: 4 consecutive beats with all products=10, bias=16 -> acc=256; pixel_out=16 with a single out_valid pulse exactly 3 cycles after beat 4.
- Positive saturation plus gaps: products=1000, bias=0, 4 beats with 2-cycle gaps between beats -> acc=24000; pixel_out=31; one out_valid; busy high from beat 1 until the output cycle.
- Negative path: products=-100, bias=0, 4 beats -> with CONV2_RELU_EN undefined pixel_out=-32; with it defined pixel_out=0.
- Back-to-back windows: 8 continuous beats, window A products=1 and bias=0 (out 1), window B products=2 and bias=-48 (acc 0, out 0) -> out_valid pulses exactly 4 cycles apart with values 1 then 0.
- Abort: enable=0 for one cycle after beat 2, then a fresh 4-beat window with products=10 and bias=16 -> no output for the aborted window; the next output is 16.
